// File: rtl/cherry_pkg.sv
// Shared types and constants for the cherry-float (18b: sign, 8b exp, 9b frac) reduction path.
// cf_sum4 is the GroupSum arithmetic: four-operand add, truncating, denormals flushed to zero.
package cherry_pkg;

  localparam int unsigned CF_W       = 18;
  localparam int unsigned GROUP      = 4;
  localparam int unsigned GS_LATENCY = 6;
  localparam int unsigned PBUF_DEPTH = 16;

  typedef logic [CF_W-1:0] cf_t;

  localparam cf_t CF_ZERO = 18'h0;

  typedef enum logic [1:0] {
    StAccept,
    StDrain,
    StDone
  } state_e;

  // Operands are aligned to the largest exponent with 3 guard bits; anything shifted past the
  // guard bits contributes nothing.
  function automatic cf_t cf_sum4(input logic [GROUP*CF_W-1:0] ops);
    cf_t               op;
    logic [7:0]        emax;
    logic [7:0]        sh;
    logic [12:0]       al;
    logic signed [15:0] acc;
    logic [15:0]       mag;
    logic [15:0]       norm;
    int                lead;
    int                e;
    emax = 8'd0;
    for (int i = 0; i < int'(GROUP); i++) begin
      op = ops[i*CF_W +: CF_W];
      if (op[16:9] > emax) emax = op[16:9];
    end
    acc = '0;
    for (int i = 0; i < int'(GROUP); i++) begin
      op = ops[i*CF_W +: CF_W];
      sh = emax - op[16:9];
      al = (op[16:9] == 8'd0 || sh > 8'd12) ? 13'd0 : ({1'b1, op[8:0], 3'b000} >> sh);
      acc = op[17] ? acc - $signed({3'b000, al}) : acc + $signed({3'b000, al});
    end
    mag = acc[15] ? 16'(-acc) : 16'(acc);
    lead = 0;
    for (int b = 0; b < 16; b++) begin
      if (mag[b]) lead = b;
    end
    norm = mag << (15 - lead);
    e = int'(emax) - 12 + lead;
    if (mag == 16'd0 || e < 1) return CF_ZERO;
    if (e > 254) return {acc[15], 8'hFE, 9'h1FF};
    return {acc[15], 8'(e), 9'(norm >> 6)};
  endfunction

endpackage

// File: rtl/group_sum.sv
// GroupSum: four-lane cherry-float adder, result valid Latency cycles after array_i is sampled.
// Pure datapath with no reset; validity is tracked by the caller.
module group_sum
  import cherry_pkg::*;
#(
  parameter int unsigned Latency = GS_LATENCY
) (
  input  logic                  clk_i,
  input  logic [GROUP*CF_W-1:0] array_i,
  output logic [CF_W-1:0]       sum_o
);

  logic [GROUP*CF_W-1:0] in_q;
  cf_t                   pipe_q [Latency-1];

  always_ff @(posedge clk_i) begin
    in_q      <= array_i;
    pipe_q[0] <= cf_sum4(in_q);
    for (int i = 1; i < int'(Latency) - 1; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign sum_o = pipe_q[Latency-2];

endmodule

// File: rtl/group_sum_pbuf.sv
// Partial-sum FIFO: one push per cycle, pop of 0..Lanes entries, head Lanes entries exposed
// oldest-first. Depth must be a power of two so the pointers wrap naturally.
module group_sum_pbuf #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 18,
  parameter int unsigned Lanes = 4,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PopW = $clog2(Lanes + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       push_data_i,
  input  logic [PopW-1:0]        pop_n_i,
  input  logic                   clear_i,
  output logic [CntW-1:0]        count_o,
  output logic [Lanes*Width-1:0] head_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q + PtrW'(pop_n_i);
    wr_ptr_d = wr_ptr_q + PtrW'(push_i);
    count_d  = count_q + CntW'(push_i) - CntW'(pop_n_i);
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_comb begin
    head_o = '0;
    for (int i = 0; i < int'(Lanes); i++) begin
      head_o[i*Width +: Width] = mem_q[rd_ptr_q + PtrW'(i)];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;

  assert property (@(posedge clk_i) disable iff (rst_i) count_q <= CntW'(Depth));
  assert property (@(posedge clk_i) disable iff (rst_i) CntW'(pop_n_i) <= count_q);

endmodule

// File: rtl/group_sum_reducer.sv
// Reduces a 4-wide beat stream of cherry floats to one sum by recirculating GroupSum results
// through a partial-sum FIFO until a single value remains.
module group_sum_reducer
  import cherry_pkg::*;
#(
  parameter int unsigned GsLatency = GS_LATENCY,
  parameter int unsigned PbufDepth = PBUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [GROUP*CF_W-1:0] in_data,
  output logic                  out_valid,
  output logic [CF_W-1:0]       out_sum,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(PbufDepth + 1);

  state_e               state_q, state_d;
  logic [GsLatency-1:0] tag_q, tag_d;
  logic                 busy_q, busy_d;
  cf_t                  out_sum_q, out_sum_d;

  logic [CntW-1:0]       count;
  logic [GROUP*CF_W-1:0] head;
  logic [GROUP*CF_W-1:0] tail_ops;
  logic [GROUP*CF_W-1:0] gs_in;
  cf_t                   gs_sum;
  logic [2:0]            pop_n;
  logic cnt_ge4, tags_empty, fb_issue, in_issue, tail_issue, complete, issue;

  // Issue slot arbitration: feedback, then input, then the padded tail group.
  always_comb begin
    cnt_ge4    = count >= CntW'(GROUP);
    tags_empty = (tag_q == '0);
    fb_issue   = cnt_ge4;
    in_issue   = (state_q == StAccept) && !cnt_ge4 && in_valid;
    tail_issue = (state_q == StDrain) && !cnt_ge4 && (count >= CntW'(2)) && tags_empty;
    complete   = (state_q == StDrain) && (count == CntW'(1)) && tags_empty;
    issue      = fb_issue | in_issue | tail_issue;
  end

  always_comb begin
    tail_ops = '0;
    for (int i = 0; i < int'(GROUP); i++) begin
      tail_ops[i*CF_W +: CF_W] = (CntW'(i) < count) ? head[i*CF_W +: CF_W] : CF_ZERO;
    end
  end

  always_comb begin
    gs_in = '0;
    pop_n = 3'd0;
    if (fb_issue) begin
      gs_in = head;
      pop_n = 3'd4;
    end else if (in_issue) begin
      gs_in = in_data;
    end else if (tail_issue) begin
      gs_in = tail_ops;
      pop_n = 3'(count);
    end
  end

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    out_sum_d = out_sum_q;
    tag_d     = {tag_q[GsLatency-2:0], issue};
    unique case (state_q)
      StAccept: begin
        if (in_issue) busy_d = 1'b1;
        if (in_issue && in_last) state_d = StDrain;
      end
      StDrain: begin
        if (complete) begin
          state_d   = StDone;
          out_sum_d = head[CF_W-1:0];
        end
      end
      StDone: begin
        state_d = StAccept;
        busy_d  = 1'b0;
      end
      default: state_d = StAccept;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StAccept;
      tag_q     <= '0;
      busy_q    <= 1'b0;
      out_sum_q <= CF_ZERO;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      busy_q    <= busy_d;
      out_sum_q <= out_sum_d;
    end
  end

  group_sum #(
    .Latency(GsLatency)
  ) u_group_sum (
    .clk_i  (clk),
    .array_i(gs_in),
    .sum_o  (gs_sum)
  );

  group_sum_pbuf #(
    .Depth(PbufDepth),
    .Width(CF_W),
    .Lanes(GROUP)
  ) u_pbuf (
    .clk_i      (clk),
    .rst_i      (reset),
    .push_i     (tag_q[GsLatency-1]),
    .push_data_i(gs_sum),
    .pop_n_i    (pop_n),
    .clear_i    (complete),
    .count_o    (count),
    .head_o     (head)
  );

  assign in_ready  = (state_q == StAccept) && !cnt_ge4;
  assign out_valid = (state_q == StDone);
  assign out_sum   = out_sum_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_group_sum_reducer.sv
// Directed bench for group_sum_reducer: table of whole vectors plus reset-mid-vector sequence.
module tb_group_sum_reducer;

  localparam logic [17:0] ONE = 18'h0FE00;
  localparam logic [17:0] M1  = 18'h2FE00;
  localparam logic [17:0] TWO = 18'h10000;
  localparam logic [17:0] M2  = 18'h30000;
  localparam logic [71:0] ALL1 = {ONE, ONE, ONE, ONE};
  localparam logic [71:0] ALL2 = {TWO, TWO, TWO, TWO};

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [71:0] in_data;
  logic        out_valid;
  logic [17:0] out_sum;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    int          nbeats;
    logic [71:0] beat;
    int          gap;     // idle cycles after each accepted beat
    logic [17:0] sum;
    int          stalls;  // cycles with in_valid high and in_ready low
    int          lat;     // last accept to out_valid; -1 = not checked
  } vec_t;

  vec_t vecs[8];

  group_sum_reducer dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_sum  (out_sum),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input int nb, input logic [71:0] b, input int g,
                              input logic [17:0] s, input int st, input int l);
    vec_t v;
    v.name = n; v.nbeats = nb; v.beat = b; v.gap = g;
    v.sum = s; v.stalls = st; v.lat = l;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int          acc_n, stalls, cyc, last_cyc, ov_cyc, gap_left;
    logic        got, busy_ov;
    logic [17:0] sum;
    acc_n = 0; stalls = 0; cyc = 0; last_cyc = 0; ov_cyc = 0; gap_left = 0;
    got = 1'b0; busy_ov = 1'b0; sum = '0;
    @(posedge clk); #1;
    in_data  = v.beat;
    in_valid = 1'b1;
    in_last  = (v.nbeats == 1);
    while (!got && cyc < 600) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1; ov_cyc = cyc; sum = out_sum; busy_ov = busy;
      end
      if (in_valid) begin
        if (in_ready) begin
          acc_n++;
          if (in_last) last_cyc = cyc;
          gap_left = v.gap;
        end else begin
          stalls++;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (acc_n >= v.nbeats) begin
        in_valid = 1'b0; in_last = 1'b0;
      end else if (gap_left > 0) begin
        in_valid = 1'b0; gap_left--;
      end else begin
        in_valid = 1'b1; in_last = (acc_n == v.nbeats - 1);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s timeout: out_valid not seen in 600 cycles, want sum %0h", v.name, v.sum);
    end else begin
      check({v.name, " sum"}, 32'(sum), 32'(v.sum));
      check({v.name, " beats accepted"}, acc_n, v.nbeats);
      check({v.name, " stall cycles"}, stalls, v.stalls);
      check({v.name, " busy at out_valid"}, 32'(busy_ov), 32'd1);
      if (v.lat >= 0) check({v.name, " latency"}, ov_cyc - last_cyc, v.lat);
      @(negedge clk);
      check({v.name, " out_valid pulse width"}, 32'(out_valid), 32'd0);
      check({v.name, " busy after done"}, 32'(busy), 32'd0);
      check({v.name, " out_sum hold"}, 32'(out_sum), 32'(v.sum));
      check({v.name, " in_ready after done"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    int stale;
    vecs[0] = mk("b1122",    1,  {TWO, TWO, ONE, ONE}, 0, 18'h10300, 0, 8);
    vecs[1] = mk("four1",    4,  ALL1,                 0, 18'h10600, 0, 15);
    vecs[2] = mk("two1",     2,  ALL1,                 0, 18'h10400, 0, 15);
    vecs[3] = mk("cancel",   1,  {M2, TWO, M1, ONE},   0, 18'h00000, 0, 8);
    vecs[4] = mk("nine1",    9,  ALL1,                 0, 18'h10840, 0, -1);  // 36.0
    vecs[5] = mk("gap2",     3,  ALL2,                 2, 18'h10700, 0, -1);  // 24.0
    vecs[6] = mk("five1",    5,  ALL1,                 0, 18'h10680, 0, -1);  // 20.0
    vecs[7] = mk("sixteen1", 16, ALL1,                 0, 18'h10A00, 2, -1);  // 64.0

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_sum", 32'(out_sum), 32'd0);
    check("reset busy", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset three cycles into a four-beat vector; in-flight partials must be dropped.
    @(posedge clk); #1;
    in_data = ALL1; in_valid = 1'b1; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset in_ready", 32'(in_ready), 32'd1);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset out_sum", 32'(out_sum), 32'd0);
    stale = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("midreset stale out_valid", stale, 0);
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: simulation still running at 500000");
    $fatal(1, "timeout");
  end

endmodule
